instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage of the 8-bit single-issue CPU. It holds the program counter and reads 32-bit instructions from instruction memory over a busywait handshake. It registers each instruction and presents its decoded fields to the control unit, register file and immediate path. It consumes `jump`, `branch` and the ALU `zero` flag to compute the next PC.

## Interface
- `PC_W`, default 32: program counter and instruction-memory address width (byte address).
- `INSTR_W`, default 32: instruction width; fixed field layout below requires 32.
- `CLK` in 1: clock; all state updates on rising edge.
- `RESET` in 1: reset, synchronous, active-high.
- `imem_addr` out `PC_W`: byte address of the instruction being fetched; equals `PC`.
- `imem_read` out 1: read request; high only in FETCH.
- `imem_readdata` in 32: instruction word; valid when `imem_busywait` is low during a read.
- `imem_busywait` in 1: memory not ready; the fetch holds while high.
- `jump` in 1: unconditional jump from the control unit, sampled in ISSUE.
- `branch` in 1: BEQ from the control unit, sampled in ISSUE.
- `zero` in 1: ALU zero flag, sampled in ISSUE.
- `stall` in 1: downstream (data memory) busy; holds ISSUE.
- `OP` out 8: instruction[31:24].
- `RD` out 8: instruction[23:16], the destination register or the branch/jump word offset.
- `RT` out 8: instruction[15:8], source 1.
- `RS_IMM` out 8: instruction[7:0], source 2 or immediate.
- `PC` out `PC_W`: address of the instruction currently held.
- `instr_valid` out 1: high in ISSUE; fields are stable and downstream may write state.
- `halted` out 1: see Configuration.

## Operation
- **States:** IDLE, FETCH, ISSUE, and HALTED (HALTED only with macro).
- **IDLE:** entered on any clock edge with `RESET` high. Next state is FETCH on the first edge with `RESET` low.
- **FETCH:**
  - `imem_read`=1.
  - On an edge with `imem_busywait`=0, latch `imem_readdata` into the instruction register and go to ISSUE.
  - Otherwise stay in FETCH with address held.
- **ISSUE:**
  - `instr_valid`=1 and the fields are driven from the instruction register.
  - If `stall`=1, stay in ISSUE with no PC change.
  - Else update PC and go to FETCH.
- **Next PC:**
  - `pc4 = PC + 4`.
  - `target = pc4 + (sext(RD) << 2)`, where the sign extension of the 8-bit offset is to `PC_W`.
  - If `jump`, or `branch && zero`: next PC = `target`. Otherwise next PC = `pc4`.
  - `jump` and `branch` both high: `jump` wins; the target is identical either way.
- **Arithmetic:** all PC arithmetic is modulo 2^`PC_W` and wraps silently. 0xFFFFFFFC + 4 = 0x00000000. A target below 0 wraps as well.
- **PC alignment:** PC[1:0] is always 00.

## Timing
- **Reset values:**
  - `PC`=0, `imem_addr`=0, `imem_read`=0.
  - `OP`/`RD`/`RT`/`RS_IMM`=0.
  - `instr_valid`=0, `halted`=0.
- **First fetch:** `imem_read` rises in the first cycle after `RESET` deasserts, with address 0.
- **Issue rate:** with zero wait states, one instruction issues every 2 cycles (FETCH, then ISSUE). Each busywait cycle or stall cycle adds 1 cycle.
- **Outputs:** all are registered or decoded from state only (Moore). Inputs never reach outputs combinationally.
- **Sample point:** `jump`, `branch`, `zero` and `stall` are sampled only at the clock edge that ends an ISSUE cycle. They are ignored in other states.
- **Reset mid-fetch or mid-issue:** the operation is aborted at that edge and all outputs return to reset values. A pending memory read is dropped; `imem_read` falls the cycle after the reset edge.
- **Fields between issues:** they hold their last value in FETCH while `instr_valid`=0.

## Configuration
- **`IFU_HALT_EN` defined:**
  - Opcode 8'hFF latched in FETCH moves the unit to HALTED instead of ISSUE.
  - HALTED: `halted`=1, `instr_valid`=0, `imem_read`=0, PC frozen at the HALT address.
  - Only `RESET` exits HALTED.
- **`IFU_HALT_EN` undefined:**
  - No HALTED state; `halted` is tied 0.
  - 8'hFF issues like any other opcode.

## Structure
- **Shared package `cpu_pkg`:**
  - Opcode constants: ADD=00, SUB=01, AND=02, OR=03, MOV=04, LOADI=05, J=06, BEQ=07, HALT=FF.
  - Instruction field bit positions.
  - Fetch state enum.
- **Sub-module `pc_next_calc`:** combinational. Inputs `PC`, offset, `jump`, `branch`, `zero`; output next PC. It is reusable by a later pipelined fetch.

## Test plan
- Release `RESET`, zero-wait memory returning 0x05040012 at address 0:
  - `imem_addr`=0 in cycle 1.
  - Next cycle: `OP`=05, `RD`=04, `RS_IMM`=12, `instr_valid`=1.
  - PC becomes 4.
- Busywait held 3 cycles on the fetch at 0x8: `imem_read` stays high with address 0x8 for 4 cycles, then ISSUE.
- J at PC 0x10 with `RD`=0xFE and `jump`=1: next PC = 0x14 − 8 = 0x0C.
- BEQ at 0x20 with `RD`=0x02:
  - `zero`=1: next PC = 0x2C.
  - `zero`=0: next PC = 0x24.
- `RESET` asserted during FETCH busywait at 0x40: the next cycle has `imem_read`=0, `PC`=0, `instr_valid`=0. The fetch then restarts at 0.
- Wrap-around: PC 0xFFFFFFFC, non-branch → PC 0x00000000.
- Halt (`IFU_HALT_EN` defined only): 0xFF000000 fetched → `halted`=1, no further reads.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, instruction field positions
// and the fetch-stage state encoding.
package cpu_pkg;

  localparam logic [7:0] OP_ADD   = 8'h00;
  localparam logic [7:0] OP_SUB   = 8'h01;
  localparam logic [7:0] OP_AND   = 8'h02;
  localparam logic [7:0] OP_OR    = 8'h03;
  localparam logic [7:0] OP_MOV   = 8'h04;
  localparam logic [7:0] OP_LOADI = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 24;
  localparam int RD_MSB = 23;
  localparam int RD_LSB = 16;
  localparam int RT_MSB = 15;
  localparam int RT_LSB = 8;
  localparam int RS_MSB = 7;
  localparam int RS_LSB = 0;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_FETCH  = 2'd1,
    FS_ISSUE  = 2'd2,
    FS_HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC: pc+4, or pc+4 + sext(offset)*4 on jump / taken branch.
module pc_next_calc #(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic [7:0]      offset,
  input  logic            jump,
  input  logic            branch,
  input  logic            zero,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] pc4;
  logic [PC_W-1:0] target;

  // All arithmetic wraps modulo 2^PC_W; the word offset is sign-extended first.
  assign pc4     = pc + PC_W'(4);
  assign target  = pc4 + ({{(PC_W-8){offset[7]}}, offset} << 2);
  assign next_pc = (jump || (branch && zero)) ? target : pc4;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, busywait instruction fetch, registered decode fields.
// Optional HALT opcode handling enabled by defining IFU_HALT_EN.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_read,
  input  logic [INSTR_W-1:0] imem_readdata,
  input  logic               imem_busywait,
  input  logic               jump,
  input  logic               branch,
  input  logic               zero,
  input  logic               stall,
  output logic [7:0]         OP,
  output logic [7:0]         RD,
  output logic [7:0]         RT,
  output logic [7:0]         RS_IMM,
  output logic [PC_W-1:0]    PC,
  output logic               instr_valid,
  output logic               halted
);

  fetch_state_e       state;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    next_pc;

  pc_next_calc #(.PC_W(PC_W)) u_pc_next (
    .pc      (pc_q),
    .offset  (ir[RD_MSB:RD_LSB]),
    .jump    (jump),
    .branch  (branch),
    .zero    (zero),
    .next_pc (next_pc)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= FS_IDLE;
      pc_q  <= '0;
      ir    <= '0;
    end else begin
      case (state)
        FS_IDLE: state <= FS_FETCH;
        FS_FETCH: begin
          if (!imem_busywait) begin
            ir <= imem_readdata;
`ifdef IFU_HALT_EN
            state <= (imem_readdata[OP_MSB:OP_LSB] == OP_HALT) ? FS_HALTED : FS_ISSUE;
`else
            state <= FS_ISSUE;
`endif
          end
        end
        FS_ISSUE: begin
          if (!stall) begin
            pc_q  <= next_pc;
            state <= FS_FETCH;
          end
        end
        // HALTED is terminal until reset; PC and fields stay frozen.
        default: state <= state;
      endcase
    end
  end

  assign PC          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_read   = (state == FS_FETCH);
  assign instr_valid = (state == FS_ISSUE);
  assign halted      = (state == FS_HALTED);
  assign OP          = ir[OP_MSB:OP_LSB];
  assign RD          = ir[RD_MSB:RD_LSB];
  assign RT          = ir[RT_MSB:RT_LSB];
  assign RS_IMM      = ir[RS_MSB:RS_LSB];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized traffic
// against a transaction-level model of the fetch/issue behaviour.
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic [31:0] imem_readdata;
  logic        imem_busywait;
  logic        jump, branch, zero, stall;
  logic [7:0]  OP, RD, RT, RS_IMM;
  logic [31:0] PC;
  logic        instr_valid, halted;

  instruction_fetch_unit #(.PC_W(32), .INSTR_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .imem_addr(imem_addr), .imem_read(imem_read),
    .imem_readdata(imem_readdata), .imem_busywait(imem_busywait),
    .jump(jump), .branch(branch), .zero(zero), .stall(stall),
    .OP(OP), .RD(RD), .RT(RT), .RS_IMM(RS_IMM),
    .PC(PC), .instr_valid(instr_valid), .halted(halted)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: what the unit is doing, where it is, and what it holds.
  localparam int P_IDLE = 0, P_FETCH = 1, P_ISSUE = 2, P_HALT = 3;
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_ir;

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    if (!mem.exists(a)) begin
      w = $urandom;
      if (w[31:24] == 8'hFF) w[31:24] = 8'h00;
      mem[a] = w;
    end
    return mem[a];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("pc",          64'(PC),          64'(m_pc));
    chk("imem_addr",   64'(imem_addr),   64'(m_pc));
    chk("imem_read",   64'(imem_read),   64'(m_phase == P_FETCH));
    chk("instr_valid", 64'(instr_valid), 64'(m_phase == P_ISSUE));
    chk("halted",      64'(halted),      64'(m_phase == P_HALT));
    chk("fields",      64'({OP, RD, RT, RS_IMM}), 64'(m_ir));
  endtask

  task automatic model_edge(input logic rst, input logic bw, input logic j,
                            input logic b, input logic z, input logic st);
    int off;
    if (rst) begin
      m_phase = P_IDLE; m_pc = 32'd0; m_ir = 32'd0;
    end else if (m_phase == P_IDLE) begin
      m_phase = P_FETCH;
    end else if (m_phase == P_FETCH) begin
      if (!bw) begin
        m_ir = mem_rd(m_pc);
`ifdef IFU_HALT_EN
        m_phase = (m_ir[31:24] == 8'hFF) ? P_HALT : P_ISSUE;
`else
        m_phase = P_ISSUE;
`endif
      end
    end else if (m_phase == P_ISSUE) begin
      if (!st) begin
        off = $signed(m_ir[23:16]);
        if (j || (b && z)) m_pc = m_pc + 32'd4 + 32'(off * 4);
        else               m_pc = m_pc + 32'd4;
        m_phase = P_FETCH;
      end
    end
  endtask

  // Called at a falling edge: drive, compare, clock, advance model.
  task automatic step(input logic rst, input logic bw, input logic j,
                      input logic b, input logic z, input logic st);
    RESET = rst; imem_busywait = bw; jump = j; branch = b; zero = z; stall = st;
    imem_readdata = mem_rd(imem_addr);
    compare_model();
    @(posedge CLK);
    model_edge(rst, bw, j, b, z, st);
    @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    RESET = 1'b1; imem_busywait = 1'b0; imem_readdata = 32'd0;
    jump = 1'b0; branch = 1'b0; zero = 1'b0; stall = 1'b0;
    m_phase = P_IDLE; m_pc = 32'd0; m_ir = 32'd0;

    mem[32'h00] = 32'h05040012;
    mem[32'h10] = 32'h06FE0000;
    mem[32'h20] = 32'h07020000;
    mem[32'h2C] = 32'h06FC0000;
    mem[32'h24] = 32'h06060000;

    @(posedge CLK); @(negedge CLK);
    chk("rst_pc",    64'(PC), 64'h0);
    chk("rst_read",  64'(imem_read), 64'h0);
    chk("rst_valid", 64'(instr_valid), 64'h0);
    chk("rst_fields", 64'({OP, RD, RT, RS_IMM}), 64'h0);
    chk("rst_halted", 64'(halted), 64'h0);
    step(1, 0, 0, 0, 0, 0);

    // First fetch at address 0, then issue of 0x05040012.
    step(0, 0, 0, 0, 0, 0);
    chk("first_read", 64'(imem_read), 64'h1);
    chk("first_addr", 64'(imem_addr), 64'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("first_op",    64'(OP), 64'h05);
    chk("first_rd",    64'(RD), 64'h04);
    chk("first_rsimm", 64'(RS_IMM), 64'h12);
    chk("first_valid", 64'(instr_valid), 64'h1);
    step(0, 0, 0, 0, 0, 0);
    chk("pc_after_first", 64'(PC), 64'h4);

    step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
    // Busywait: read held at 0x8 for 4 cycles.
    for (int i = 0; i < 3; i++) begin
      chk("bw_read", 64'(imem_read), 64'h1);
      chk("bw_addr", 64'(imem_addr), 64'h8);
      step(0, 1, 0, 0, 0, 0);
    end
    chk("bw_read_last", 64'(imem_read), 64'h1);
    step(0, 0, 0, 0, 0, 0);
    chk("bw_then_issue", 64'(instr_valid), 64'h1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
    // J at 0x10 with offset 0xFE.
    step(0, 0, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
    chk("jump_back", 64'(PC), 64'hC);
    for (int i = 0; i < 5; i++) begin step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0); end
    chk("at_beq", 64'(PC), 64'h20);
    step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 1, 1, 0);
    chk("beq_taken", 64'(PC), 64'h2C);
    step(0, 0, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 1, 0, 0);
    chk("beq_not_taken", 64'(PC), 64'h24);
    step(0, 0, 0, 0, 0, 0); step(0, 0, 1, 1, 1, 0);
    chk("jump_fwd", 64'(PC), 64'h40);

    // Reset during busywait at 0x40.
    step(0, 1, 0, 0, 0, 0); step(1, 1, 0, 0, 0, 0);
    chk("midrst_read",  64'(imem_read), 64'h0);
    chk("midrst_pc",    64'(PC), 64'h0);
    chk("midrst_valid", 64'(instr_valid), 64'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("restart_read", 64'(imem_read), 64'h1);
    chk("restart_addr", 64'(imem_addr), 64'h0);

    // Jump far backwards from 0x4 to wrap below zero, then walk up to the top.
    mem[32'h04] = 32'h06800000;
    step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
    chk("neg_target", 64'(PC), 64'hFFFFFE08);
    guard = 0;
    while (m_pc != 32'hFFFFFFFC && guard < 2000) begin
      step(0, $urandom_range(0, 3) == 0, 0, $urandom_range(0, 1), 0,
           $urandom_range(0, 3) == 0);
      guard++;
    end
    chk("wrap_top", 64'(PC), 64'hFFFFFFFC);
    step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
    chk("wrap_zero", 64'(PC), 64'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1), $urandom_range(0, 3) == 0);

    // Opcode 0xFF at address 0.
    mem[32'h00] = 32'hFF000000;
    step(1, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
`ifdef IFU_HALT_EN
    chk("halt_flag", 64'(halted), 64'h1);
    chk("halt_valid", 64'(instr_valid), 64'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 1, 0);
    chk("halt_noread", 64'(imem_read), 64'h0);
    chk("halt_pc", 64'(PC), 64'h0);
`else
    chk("ff_issues", 64'(instr_valid), 64'h1);
    chk("ff_op", 64'(OP), 64'hFF);
    step(0, 0, 0, 0, 0, 0);
    chk("ff_next", 64'(PC), 64'h4);
    chk("ff_halted", 64'(halted), 64'h0);
`endif
    step(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
